// File: rtl/weight_bram_writer_if.sv
// rtl/weight_bram_writer_if.sv - weight stream input and BRAM port-A write bus
interface weight_bram_writer_if #(
    parameter int DW        = 16,
    parameter int Dimension = 16,
    parameter int ADDR_W    = 6
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DW-1:0]        s_data;
    logic                 s_last;
    logic [Dimension-1:0] wea;
    logic [ADDR_W-1:0]    addra;
    logic [DW-1:0]        dina;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, wea, addra, dina
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, wea, addra, dina
    );
endinterface

// File: rtl/weight_bram_writer.sv
// rtl/weight_bram_writer.sv - loads a lane-major weight stream into the per-row weight BRAMs
// Optional: WEIGHT_WR_ZERO_FILL_EN pads every lane with zeros out to Dimension taps.
module weight_bram_writer #(
    parameter int DW        = 16,
    parameter int Dimension = 16,
    parameter int ADDR_W    = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [4:0]          kernel_size,
    input  logic [ADDR_W-1:0]   base_addr,
    weight_bram_writer_if.slave wif,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int TW = ($clog2(Dimension + 1) > 5) ? $clog2(Dimension + 1) : 5;
    localparam int LW = (Dimension > 1) ? $clog2(Dimension) : 1;
    localparam logic [TW-1:0] DIM_T     = TW'(Dimension);
    localparam logic [LW-1:0] LAST_LANE = LW'(Dimension - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
`ifdef WEIGHT_WR_ZERO_FILL_EN
        , S_ZFILL
`endif
    } state_t;

    state_t               state_q, state_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [TW-1:0]        tap_q, tap_d;
    logic [TW-1:0]        k_q, k_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic                 err_q, err_d;
    logic [Dimension-1:0] wea_q, wea_d;
    logic [ADDR_W-1:0]    addra_q, addra_d;
    logic [DW-1:0]        dina_q, dina_d;

    logic                 s_ready;
    logic                 beat;
    logic                 last_tap;
    logic                 last_lane;
    logic [TW-1:0]        ks_ext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            tap_q   <= '0;
            k_q     <= '0;
            base_q  <= '0;
            err_q   <= 1'b0;
            wea_q   <= '0;
            addra_q <= '0;
            dina_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            tap_q   <= tap_d;
            k_q     <= k_d;
            base_q  <= base_d;
            err_q   <= err_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        tap_d     = tap_q;
        k_d       = k_q;
        base_d    = base_q;
        err_d     = err_q;
        wea_d     = '0;
        addra_d   = addra_q;
        dina_d    = dina_q;
        ks_ext    = TW'(kernel_size);
        s_ready   = (state_q == S_LOAD);
        beat      = s_ready && wif.s_valid;
        last_tap  = (tap_q == k_q - TW'(1));
        last_lane = (lane_q == LAST_LANE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    k_d    = ks_ext;
                    base_d = base_addr;
                    lane_d = '0;
                    tap_d  = '0;
                    if ((ks_ext == '0) || (ks_ext > DIM_T)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end

            S_LOAD: begin
                if (beat) begin
                    wea_d[lane_q] = 1'b1;
                    addra_d       = base_q + ADDR_W'(tap_q);
                    dina_d        = wif.s_data;
                    tap_d         = last_tap ? '0 : tap_q + TW'(1);
                    // s_last must coincide exactly with the final beat of the set
                    if (wif.s_last != (last_tap && last_lane)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else if (last_tap) begin
`ifdef WEIGHT_WR_ZERO_FILL_EN
                        if (k_q != DIM_T) begin
                            tap_d   = k_q;
                            state_d = S_ZFILL;
                        end else
`endif
                        if (last_lane) begin
                            state_d = S_DONE;
                        end else begin
                            lane_d = lane_q + LW'(1);
                        end
                    end
                end
            end

`ifdef WEIGHT_WR_ZERO_FILL_EN
            S_ZFILL: begin
                wea_d[lane_q] = 1'b1;
                addra_d       = base_q + ADDR_W'(tap_q);
                dina_d        = '0;
                if (tap_q == DIM_T - TW'(1)) begin
                    tap_d = '0;
                    if (last_lane) begin
                        state_d = S_DONE;
                    end else begin
                        lane_d  = lane_q + LW'(1);
                        state_d = S_LOAD;
                    end
                end else begin
                    tap_d = tap_q + TW'(1);
                end
            end
`endif

            // Hold until the last registered write has left the port, so done trails it
            S_DONE: begin
                if (wea_q == '0) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    assign wif.s_ready = s_ready;
    assign wif.wea     = wea_q;
    assign wif.addra   = addra_q;
    assign wif.dina    = dina_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE) && (wea_q == '0);
    assign err         = err_q;
endmodule

// File: tb/tb_weight_bram_writer.sv
// tb/tb_weight_bram_writer.sv - randomized scoreboard bench for weight_bram_writer
module tb_weight_bram_writer;
    localparam int D  = 16;
    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic [4:0]    kernel_size;
    logic [AW-1:0] base_addr;
    logic          busy;
    logic          done;
    logic          err;

    weight_bram_writer_if #(.DW(DW), .Dimension(D), .ADDR_W(AW)) wif ();

    weight_bram_writer #(.DW(DW), .Dimension(D), .ADDR_W(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .kernel_size (kernel_size),
        .base_addr   (base_addr),
        .wif         (wif),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    typedef struct {
        int          cyc;
        logic [D-1:0]  wea;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t           exp_q[$];
    logic [DW-1:0] mem [D][64];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            start_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every DUT write is matched against the oldest expected write
    initial forever begin
        wr_t e;
        @(negedge clk);
        if (wif.wea != '0) begin
            wr_cnt = wr_cnt + 1;
            for (int l = 0; l < D; l++) begin
                if (wif.wea[l]) mem[l][wif.addra] = wif.dina;
            end
            if (exp_q.size() == 0) begin
                check("write_unexpected", int'(wif.wea), 0);
            end else begin
                e = exp_q.pop_front();
                check("write_cycle", cyc, e.cyc);
                check("write_wea", int'(wif.wea), int'(e.wea));
                check("write_addr", int'(wif.addra), int'(e.addr));
                check("write_data", int'(wif.dina), int'(e.data));
            end
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // Beat i of a load lands in lane i/K at base + i%K, one cycle after acceptance
    task automatic do_load(input int k, input int base, input int last_at, input int gap,
                           input int stop_n, input bit do_abort, input bit seq_data);
        int total, lim, idx, budget;
        bit v, fin;
        total = D * k;
        lim = (stop_n < total) ? stop_n : total;
        start = 1'b1;
        kernel_size = 5'(k);
        base_addr = AW'(base);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_cleared_on_start", int'(err), 0);
        idx = 0;
        fin = 1'b0;
        budget = 0;
        while (!fin && idx < lim && budget < 5000) begin
            v = ($urandom_range(99) >= gap) || (do_abort && idx == lim - 1);
            wif.s_valid = v;
            wif.s_data = seq_data ? DW'(idx) : DW'($urandom);
            wif.s_last = (idx == last_at);
            abort = do_abort && (idx == lim - 1);
            if (v && wif.s_ready) begin
                exp_q.push_back('{cyc + 1, D'(1) << (idx / k), AW'(base + idx % k), wif.s_data});
                idx++;
                if (wif.s_last) fin = 1'b1;
            end
            @(posedge clk); #1;
            abort = 1'b0;
            budget++;
        end
        wif.s_valid = 1'b0;
        wif.s_last = 1'b0;
        check("load_progress", int'(budget < 5000), 1);
    endtask

    task automatic wait_done(input int d0);
        for (int i = 0; i < 100 && done_cnt == d0; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic finish_load(input int d0, input int w0, input int nwr, input int exp_err);
        wait_done(d0);
        repeat (2) begin @(posedge clk); #1; end
        check("done_pulses", done_cnt - d0, 1);
        check("write_count", wr_cnt - w0, nwr);
        check("err_flag", int'(err), exp_err);
        check("busy_after", int'(busy), 0);
        check("scoreboard_empty", exp_q.size(), 0);
    endtask

    task automatic bad_config(input int k);
        int d0, w0;
        d0 = done_cnt;
        w0 = wr_cnt;
        start = 1'b1;
        kernel_size = 5'(k);
        base_addr = AW'(5);
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(d0);
        repeat (2) begin @(posedge clk); #1; end
        check("badcfg_done_latency", done_cyc - start_cyc, 1);
        check("badcfg_done_pulses", done_cnt - d0, 1);
        check("badcfg_no_writes", wr_cnt - w0, 0);
        check("badcfg_err", int'(err), 1);
    endtask

    initial begin
        int d0, w0, k, b;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        kernel_size = '0;
        base_addr = '0;
        wif.s_valid = 1'b0;
        wif.s_data = '0;
        wif.s_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", int'(wif.s_ready), 0);
        check("rst_wea", int'(wif.wea), 0);
        check("rst_addra", int'(wif.addra), 0);
        check("rst_dina", int'(wif.dina), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // K=3, base 0, sequential data at full throughput
        d0 = done_cnt; w0 = wr_cnt;
        do_load(3, 0, 47, 0, 1000, 1'b0, 1'b1);
        finish_load(d0, w0, 48, 0);
        check("k3_done_latency", done_cyc - start_cyc, 50);
        for (int l = 0; l < D; l++)
            for (int t = 0; t < 3; t++)
                check("k3_bram_content", int'(mem[l][t]), 3 * l + t);

        // K=16, base 32, 50% valid gaps
        d0 = done_cnt; w0 = wr_cnt;
        do_load(16, 32, 255, 50, 1000, 1'b0, 1'b0);
        finish_load(d0, w0, 256, 0);

        // Early s_last on beat 10
        d0 = done_cnt; w0 = wr_cnt;
        do_load(3, 0, 10, 20, 1000, 1'b0, 1'b0);
        finish_load(d0, w0, 11, 1);

        bad_config(0);
        bad_config(17);

        // Valid start clears err; address range wraps past 63
        d0 = done_cnt; w0 = wr_cnt;
        do_load(5, 60, 79, 25, 1000, 1'b0, 1'b0);
        finish_load(d0, w0, 80, 0);

        // Final beat without s_last
        d0 = done_cnt; w0 = wr_cnt;
        do_load(2, 9, -1, 10, 1000, 1'b0, 1'b0);
        finish_load(d0, w0, 32, 1);

        // Abort on the 21st beat
        d0 = done_cnt; w0 = wr_cnt;
        do_load(4, 3, -1, 30, 21, 1'b1, 1'b0);
        check("abort_busy_low", int'(busy), 0);
        repeat (30) begin @(posedge clk); #1; end
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_write_limit", int'((wr_cnt - w0) <= 21), 1);
        check("abort_scoreboard_empty", exp_q.size(), 0);

        // Asynchronous reset mid-load
        do_load(5, 7, -1, 0, 7, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("midrst_s_ready", int'(wif.s_ready), 0);
        check("midrst_wea", int'(wif.wea), 0);
        check("midrst_addra", int'(wif.addra), 0);
        check("midrst_dina", int'(wif.dina), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(err), 0);
        w0 = wr_cnt;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst_no_writes", wr_cnt - w0, 0);
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk); #1;

        // Random loads after recovery
        for (int n = 0; n < 2; n++) begin
            k = $urandom_range(16, 1);
            b = $urandom_range(63, 0);
            d0 = done_cnt; w0 = wr_cnt;
            do_load(k, b, D * k - 1, 30, 1000, 1'b0, 1'b0);
            finish_load(d0, w0, D * k, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
